// File: rtl/cmd_writer_if.sv
// Memory read port and CMD byte stream of cmd_writer.
// The master modport is the writer; the slave modport is memory plus stream sink.
interface cmd_writer_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic [7:0]  up_data;
    logic        up_valid;
    logic        up_ready;

    modport master (
        output mem_addr, mem_rd, up_data, up_valid,
        input  mem_data, up_ready
    );

    modport slave (
        input  mem_addr, mem_rd, up_data, up_valid,
        output mem_data, up_ready
    );
endinterface

// File: rtl/cmd_writer.sv
// cmd_writer: streams a memory range as TRS-80 CMD load records followed by a transfer record.
// Defining CMD_WRITER_HDR_EN adds a leading header record (0x05, 0x06, HDR_NAME).
module cmd_writer #(
    parameter int unsigned BLOCK_MAX = 256,
    parameter logic [47:0] HDR_NAME  = 48'h545253383020
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] end_addr,
    input  logic [15:0] exec_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    cmd_writer_if.master bus
);
    localparam logic [16:0] BLOCK_MAX_W = 17'(BLOCK_MAX);

    typedef enum logic [3:0] {
        IDLE,
`ifdef CMD_WRITER_HDR_EN
        HDR,
`endif
        REC_TYPE,
        REC_LEN,
        ADDR_LO,
        ADDR_HI,
        DATA_RD,
        DATA_WAIT,
        DATA_OUT,
        XFER_TYPE,
        XFER_LEN,
        XFER_LO,
        XFER_HI,
        FINISH
    } state_t;

`ifdef CMD_WRITER_HDR_EN
    localparam state_t FIRST_STATE = HDR;
`else
    localparam state_t FIRST_STATE = REC_TYPE;
`endif

    state_t      state_r;
    logic [15:0] mem_addr_r;
    logic        mem_rd_r;
    logic [7:0]  up_data_r;
    logic        up_valid_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;
    logic [15:0] exec_r;
    logic [16:0] remain_r;
    logic [8:0]  rec_n_r;
    logic [7:0]  data_r;
`ifdef CMD_WRITER_HDR_EN
    logic [2:0]  hdr_idx_r;
`endif

    logic        emit_s;
    logic [7:0]  byte_s;
    logic [8:0]  blk_n_s;
    logic [16:0] span_s;

`ifdef CMD_WRITER_HDR_EN
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        logic [47:0] name_s;
        name_s = HDR_NAME << {idx - 3'd2, 3'b000};
        if (idx == 3'd0) begin
            hdr_byte = 8'h05;
        end else if (idx == 3'd1) begin
            hdr_byte = 8'h06;
        end else begin
            hdr_byte = name_s[47:40];
        end
    endfunction
`endif

    assign blk_n_s = (remain_r > BLOCK_MAX_W) ? BLOCK_MAX_W[8:0] : remain_r[8:0];
    assign span_s  = {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;

    // Byte owed by the current state, and whether the state emits a byte at all.
    always_comb begin
        emit_s = 1'b1;
        byte_s = 8'h00;
        case (state_r)
`ifdef CMD_WRITER_HDR_EN
            HDR:       byte_s = hdr_byte(hdr_idx_r);
`endif
            REC_TYPE:  byte_s = 8'h01;
            REC_LEN:   byte_s = rec_n_r[7:0] + 8'd2;
            ADDR_LO:   byte_s = mem_addr_r[7:0];
            ADDR_HI:   byte_s = mem_addr_r[15:8];
            DATA_OUT:  byte_s = data_r;
            XFER_TYPE: byte_s = 8'h02;
            XFER_LEN:  byte_s = 8'h02;
            XFER_LO:   byte_s = exec_r[7:0];
            XFER_HI:   byte_s = exec_r[15:8];
            default:   emit_s = 1'b0;
        endcase
    end

    // Save sequencer; a byte state first loads up_data, then waits for the sink to take it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            mem_addr_r <= 16'h0000;
            mem_rd_r   <= 1'b0;
            up_data_r  <= 8'h00;
            up_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            exec_r     <= 16'h0000;
            remain_r   <= 17'd0;
            rec_n_r    <= 9'd0;
            data_r     <= 8'h00;
`ifdef CMD_WRITER_HDR_EN
            hdr_idx_r  <= 3'd0;
`endif
        end else begin
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            mem_rd_r <= 1'b0;
            if (emit_s && !up_valid_r) begin
                up_valid_r <= 1'b1;
                up_data_r  <= byte_s;
            end else if (emit_s && !bus.up_ready) begin
                up_valid_r <= 1'b1;
            end else begin
                up_valid_r <= 1'b0;
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            if (end_addr < start_addr) begin
                                error_r <= 1'b1;
                            end else begin
                                busy_r     <= 1'b1;
                                mem_addr_r <= start_addr;
                                exec_r     <= exec_addr;
                                remain_r   <= span_s;
`ifdef CMD_WRITER_HDR_EN
                                hdr_idx_r  <= 3'd0;
`endif
                                state_r    <= FIRST_STATE;
                            end
                        end
                    end
`ifdef CMD_WRITER_HDR_EN
                    HDR: begin
                        if (hdr_idx_r == 3'd7) begin
                            state_r <= REC_TYPE;
                        end else begin
                            hdr_idx_r <= hdr_idx_r + 3'd1;
                        end
                    end
`endif
                    REC_TYPE: begin
                        rec_n_r <= blk_n_s;
                        state_r <= REC_LEN;
                    end
                    REC_LEN:   state_r <= ADDR_LO;
                    ADDR_LO:   state_r <= ADDR_HI;
                    ADDR_HI: begin
                        mem_rd_r <= 1'b1;
                        state_r  <= DATA_RD;
                    end
                    DATA_RD:   state_r <= DATA_WAIT;
                    DATA_WAIT: begin
                        data_r  <= bus.mem_data;
                        state_r <= DATA_OUT;
                    end
                    DATA_OUT: begin
                        remain_r <= remain_r - 17'd1;
                        rec_n_r  <= rec_n_r - 9'd1;
                        // The byte count always ends the save before the address could wrap.
                        if (mem_addr_r != 16'hFFFF) begin
                            mem_addr_r <= mem_addr_r + 16'd1;
                        end
                        if (rec_n_r == 9'd1) begin
                            state_r <= (remain_r == 17'd1) ? XFER_TYPE : REC_TYPE;
                        end else begin
                            mem_rd_r <= 1'b1;
                            state_r  <= DATA_RD;
                        end
                    end
                    XFER_TYPE: state_r <= XFER_LEN;
                    XFER_LEN:  state_r <= XFER_LO;
                    XFER_LO:   state_r <= XFER_HI;
                    XFER_HI:   state_r <= FINISH;
                    FINISH: begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    default:   state_r <= IDLE;
                endcase
            end
        end
    end

    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_rd   = mem_rd_r;
    assign bus.up_data  = up_data_r;
    assign bus.up_valid = up_valid_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
endmodule

// File: tb/tb_cmd_writer.sv
// Self-checking bench for cmd_writer: table of saves, hand-written corner cases and random saves,
// all compared against a record-level model of the CMD stream.
module tb_cmd_writer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] start_addr, end_addr, exec_addr;
    logic        busy, done, error;

    cmd_writer_if bus();

    cmd_writer dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .start_addr(start_addr), .end_addr(end_addr), .exec_addr(exec_addr),
        .busy(busy), .done(done), .error(error), .bus(bus)
    );

    always #5 clock = ~clock;

`ifdef CMD_WRITER_HDR_EN
    localparam int HDR_LEN = 8;
`else
    localparam int HDR_LEN = 0;
`endif
    localparam int BMAX = 256;

    logic [7:0] mem [0:65535];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int checks = 0, errors = 0;
    int done_cnt, err_cnt, busy_cnt, rd_cnt;
    int rd_valid_viol = 0, stall_viol = 0, stall_seen = 0;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    typedef struct {
        logic [15:0] s, e, x;
        bit          rnd;
        bit          err;
        int          nbytes;
    } vec_t;
    vec_t vt[7];

    // Memory answers one cycle after mem_rd.
    always @(posedge clock) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    // Observe the stream away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.up_valid && bus.up_ready) got_q.push_back(bus.up_data);
            if (bus.mem_rd && bus.up_valid) rd_valid_viol++;
            if (prev_valid && !prev_ready) begin
                stall_seen++;
                if (!bus.up_valid || bus.up_data != prev_data) stall_viol++;
            end
            if (bus.mem_rd) rd_cnt++;
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (busy) busy_cnt++;
            prev_valid = bus.up_valid;
            prev_ready = bus.up_ready;
            prev_data  = bus.up_data;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference stream built record by record from the address range.
    function automatic void build_model(input logic [15:0] s, input logic [15:0] e, input logic [15:0] x);
        int addr, rem, n;
        exp_q.delete();
        if (e < s) return;
`ifdef CMD_WRITER_HDR_EN
        begin
            logic [47:0] nm;
            nm = 48'h545253383020;
            exp_q.push_back(8'h05);
            exp_q.push_back(8'h06);
            for (int i = 0; i < 6; i++) exp_q.push_back(8'(nm >> (40 - 8 * i)));
        end
`endif
        addr = int'(s);
        rem  = int'(e) - int'(s) + 1;
        while (rem > 0) begin
            n = (rem > BMAX) ? BMAX : rem;
            exp_q.push_back(8'h01);
            exp_q.push_back(8'((n + 2) % 256));
            exp_q.push_back(8'(addr % 256));
            exp_q.push_back(8'(addr / 256));
            for (int i = 0; i < n; i++) exp_q.push_back(mem[addr + i]);
            addr += n;
            rem  -= n;
        end
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        exp_q.push_back(x[7:0]);
        exp_q.push_back(x[15:8]);
    endfunction

    task automatic check_stream(input string name);
        int bad;
        bad = -1;
        check({name, " length"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s bytes: first difference at %0d got 0x%0h expected 0x%0h",
                     name, bad, got_q[bad], exp_q[bad]);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, " up_valid"}, bus.up_valid, 0);
        check({name, " up_data"}, bus.up_data, 0);
        check({name, " mem_rd"}, bus.mem_rd, 0);
        check({name, " mem_addr"}, bus.mem_addr, 0);
        check({name, " busy"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " error"}, error, 0);
    endtask

    task automatic run_save(input logic [15:0] s, input logic [15:0] e, input logic [15:0] x,
                            input bit rnd, input bit poke, input int budget, output bit timeout);
        int cyc;
        got_q.delete();
        done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        build_model(s, e, x);
        start_addr = s; end_addr = e; exec_addr = x; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        start_addr = 16'($urandom); end_addr = 16'($urandom); exec_addr = 16'($urandom);
        cyc = 0;
        while (done_cnt == 0 && err_cnt == 0 && cyc < budget) begin
            bus.up_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (poke && cyc == 20) ? 1'b1 : 1'b0;
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0;
        bus.up_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        timeout = (cyc >= budget);
        if (timeout) begin
            reset_n = 1'b0;
            repeat (2) @(posedge clock);
            #1 reset_n = 1'b1;
        end
    endtask

    task automatic verify(input string name, input bit exp_err, input int exp_len, input bit timeout);
        check({name, " timeout"}, timeout, 0);
        check({name, " error pulses"}, err_cnt, exp_err ? 1 : 0);
        check({name, " done pulses"}, done_cnt, exp_err ? 0 : 1);
        check({name, " busy seen"}, busy_cnt > 0, exp_err ? 0 : 1);
        check({name, " busy after"}, busy, 0);
        check({name, " byte count"}, got_q.size(), exp_len);
        check_stream(name);
    endtask

    initial begin
        bit to;
        logic [15:0] rs, rx;
        int rl, wait_cyc;
        logic [7:0] e36[11];
        logic [7:0] r39[5];

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
        mem[16'h5200] = 8'hAA; mem[16'h5201] = 8'hBB; mem[16'h5202] = 8'hCC;

        vt[0] = '{16'h5200, 16'h5202, 16'h5200, 1'b0, 1'b0, 11};
        vt[1] = '{16'h6000, 16'h60FD, 16'h6000, 1'b0, 1'b0, 262};
        vt[2] = '{16'h6000, 16'h6100, 16'h6000, 1'b1, 1'b0, 269};
        vt[3] = '{16'h8000, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 0};
        vt[4] = '{16'hFFFF, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 9};
        vt[5] = '{16'h0000, 16'h0000, 16'hABCD, 1'b0, 1'b0, 9};
        vt[6] = '{16'h1234, 16'h1333, 16'h4321, 1'b1, 1'b0, 264};

        reset_n = 1'b0; start = 1'b0;
        start_addr = 16'h0; end_addr = 16'h0; exec_addr = 16'h0;
        bus.up_ready = 1'b0; bus.mem_data = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        foreach (vt[k]) begin
            run_save(vt[k].s, vt[k].e, vt[k].x, vt[k].rnd, 1'b0, 4000, to);
            verify($sformatf("vec%0d", k), vt[k].err, vt[k].err ? 0 : vt[k].nbytes + HDR_LEN, to);
        end

        // Short save with known memory contents.
        e36 = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h52};
        run_save(16'h5200, 16'h5202, 16'h5200, 1'b0, 1'b0, 400, to);
        for (int i = 0; i < 11; i++) check($sformatf("basic byte%0d", i), got_q[HDR_LEN + i], e36[i]);
`ifdef CMD_WRITER_HDR_EN
        check("hdr b0", got_q[0], 8'h05); check("hdr b1", got_q[1], 8'h06);
        check("hdr b2", got_q[2], 8'h54); check("hdr b7", got_q[7], 8'h20);
`endif

        // LEN wraps: 254 bytes give 0x00, 257 bytes split into 256 + 1.
        run_save(16'h6000, 16'h60FD, 16'h6000, 1'b0, 1'b0, 4000, to);
        check("len254", got_q[HDR_LEN + 1], 8'h00);
        run_save(16'h6000, 16'h6100, 16'h6000, 1'b0, 1'b0, 4000, to);
        check("len256", got_q[HDR_LEN + 1], 8'h02);
        check("rec2 type", got_q[HDR_LEN + 260], 8'h01);
        check("rec2 len", got_q[HDR_LEN + 261], 8'h03);
        check("rec2 lo", got_q[HDR_LEN + 262], 8'h00);
        check("rec2 hi", got_q[HDR_LEN + 263], 8'h61);

        // Top-of-memory single byte.
        r39 = '{8'h01, 8'h03, 8'hFF, 8'hFF, 8'h5A};
        run_save(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 400, to);
        for (int i = 0; i < 5; i++) check($sformatf("top byte%0d", i), got_q[HDR_LEN + i], r39[i]);
        check("top mem_addr", bus.mem_addr, 16'hFFFF);

        // Reset while the second record is presenting data.
        got_q.delete();
        start_addr = 16'h1000; end_addr = 16'h11FF; exec_addr = 16'h1000; start = 1'b1;
        bus.up_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_cyc = 0;
        while (!(got_q.size() >= HDR_LEN + 265 && bus.up_valid) && wait_cyc < 3000) begin
            @(posedge clock); #1;
            wait_cyc++;
        end
        check("abort reached rec2", wait_cyc < 3000, 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("abort");
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        got_q.delete();
        rd_cnt = 0;
        repeat (10) @(posedge clock);
        #1;
        check("abort quiet bytes", got_q.size(), 0);
        check("abort quiet mem_rd", rd_cnt, 0);
        run_save(16'h1000, 16'h11FF, 16'h1000, 1'b0, 1'b0, 4000, to);
        verify("restart", 1'b0, 512 + 12 + HDR_LEN, to);

        // Random saves with a stalling sink and a start poked mid-save.
        for (int r = 0; r < 6; r++) begin
            rl = $urandom_range(16, 600);
            rs = 16'($urandom_range(0, 16'hF000));
            rx = 16'($urandom);
            run_save(rs, 16'(int'(rs) + rl - 1), rx, 1'b1, 1'b1, rl * 16 + 400, to);
            verify($sformatf("rand%0d", r), 1'b0, rl + 4 * ((rl + BMAX - 1) / BMAX) + 4 + HDR_LEN, to);
        end

        check("mem_rd with up_valid", rd_valid_viol, 0);
        check("stall stability", stall_viol, 0);
        check("stalls exercised", stall_seen > 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
